// File: rtl/fft_sample_buffer.sv
// Working-sample RAM and frame sequencer for the in-place FFT core: bit-reversed
// load, core hand-off, natural-order unload, then a one-cycle core clear.
module fft_sample_buffer #(
  parameter  int BIT_WIDTH = 8,
  parameter  int MODE_NUM  = 3,
  parameter  int FFT_SIZE  = 16,
  localparam int ADDR_W    = $clog2(FFT_SIZE),
  localparam int MODE_W    = $clog2(MODE_NUM),
  localparam int DW        = 2 * BIT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DW-1:0]     in_data_i,
  output logic              fft_init_o,
  output logic              fft_clr_o,
  input  logic              fft_ready_i,
  input  logic [ADDR_W-1:0] fft_addr_i,
  input  logic              fft_wr_en_i,
  input  logic [DW-1:0]     fft_wdata_i,
  output logic [DW-1:0]     fft_rdata_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DW-1:0]     out_data_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_RUN, S_UNLOAD, S_CLR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [DW-1:0]       mem_q [FFT_SIZE];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DW-1:0]       mem_wdata;
  int                  n_bits;
  logic [ADDR_W-1:0]   n_last;

  // Reverse only the low n bits; the upper address bits stay zero.
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a, input int n);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W; i++)
      if (i < n) r[i] = a[n-1-i];
    return r;
  endfunction

  assign n_bits = 2 + int'(mode_q);
  assign n_last = ADDR_W'((1 << n_bits) - 1);

  assign fft_rdata_o = mem_q[fft_addr_i];
  assign out_data_o  = mem_q[cnt_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    in_ready_o  = 1'b0;
    fft_init_o  = 1'b0;
    fft_clr_o   = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // Sizes beyond the largest supported one fall back to the largest.
          mode_d  = (mode_i >= MODE_W'(MODE_NUM-1)) ? MODE_W'(MODE_NUM-1) : mode_i;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          mem_we    = 1'b1;
          mem_waddr = bitrev(cnt_q, n_bits);
          mem_wdata = in_data_i;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == n_last) begin
            cnt_d   = '0;
            state_d = S_KICK;
          end
        end
      end
      S_KICK: begin
        fft_init_o = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (fft_wr_en_i) begin
          mem_we    = 1'b1;
          mem_waddr = fft_addr_i;
          mem_wdata = fft_wdata_i;
        end
        if (fft_ready_i) begin
          cnt_d   = '0;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == n_last) begin
            cnt_d   = '0;
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        fft_clr_o = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // RAM is deliberately not reset; a write racing a reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule
